// File: rtl/gamma_pkg.sv
// Shared defaults and helpers for the piecewise-linear gamma corrector.
package gamma_pkg;

    localparam int DW_DEF        = 12;
    localparam int NCH_DEF       = 3;
    localparam int SEG_BITS_DEF  = 5;
    localparam int FRAC_BITS_DEF = DW_DEF - SEG_BITS_DEF;

    function automatic int nknot(input int seg_bits);
        return (1 << seg_bits) + 1;
    endfunction

    // Identity knot i: i * 2^frac_bits, saturated to full scale for the last knot.
    function automatic logic [63:0] ident_knot(input int i, input int frac_bits, input int dw);
        logic [63:0] v;
        logic [63:0] m;
        v = 64'(i) << frac_bits;
        m = (64'd1 << dw) - 64'd1;
        return (v > m) ? m : v;
    endfunction

    function automatic logic [63:0] clamp_u(input logic signed [63:0] v, input int dw);
        logic signed [63:0] m;
        m = (64'sd1 <<< dw) - 64'sd1;
        if (v < 0)
            return '0;
        else if (v > m)
            return m;
        else
            return v;
    endfunction

endpackage

// File: rtl/gamma_pwl_lane.sv
// One colour channel: two knot banks and the lookup / multiply / round-clamp pipeline.
module gamma_pwl_lane
    import gamma_pkg::*;
#(
    parameter int DW       = DW_DEF,
    parameter int SEG_BITS = SEG_BITS_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic                v1,
    input  logic                v2,
    input  logic                byp2,
    input  logic                sel,
    input  logic                we,
    input  logic [SEG_BITS:0]   waddr,
    input  logic [DW-1:0]       wdata,
    input  logic [DW-1:0]       x,
    output logic [DW-1:0]       y
);

    localparam int FB = DW - SEG_BITS;
    localparam int NK = nknot(SEG_BITS);
    localparam int PW = DW + FB + 1;
    localparam logic [PW:0] HALF = {{(PW - FB + 1){1'b0}}, 1'b1, {(FB - 1){1'b0}}};

    logic [DW-1:0] bank0 [NK];
    logic [DW-1:0] bank1 [NK];

    // sel names the active bank; writes always go to the other one.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NK; i++) begin
                bank0[i] <= DW'(ident_knot(i, FB, DW));
                bank1[i] <= DW'(ident_knot(i, FB, DW));
            end
        end else if (we) begin
            if (sel)
                bank0[waddr] <= wdata;
            else
                bank1[waddr] <= wdata;
        end
    end

    logic [SEG_BITS:0]      i_lo;
    logic [SEG_BITS:0]      i_hi;
    logic [DW-1:0]          k_lo;
    logic [DW-1:0]          k_hi;
    logic signed [DW:0]     diff_n;

    always_comb begin
        i_lo   = {1'b0, x[DW-1:FB]};
        i_hi   = i_lo + (SEG_BITS + 1)'(1);
        k_lo   = sel ? bank1[i_lo] : bank0[i_lo];
        k_hi   = sel ? bank1[i_hi] : bank0[i_hi];
        diff_n = $signed({1'b0, k_hi}) - $signed({1'b0, k_lo});
    end

    logic [DW-1:0]          s1_lo;
    logic signed [DW:0]     s1_diff;
    logic [FB-1:0]          s1_frac;
    logic [DW-1:0]          s1_x;
    logic [DW-1:0]          s2_lo;
    logic signed [PW-1:0]   s2_prod;
    logic [DW-1:0]          s2_x;

    logic signed [PW-1:0]   diff_x;
    logic signed [PW-1:0]   frac_x;
    logic signed [PW-1:0]   prod_n;
    logic [PW:0]            rnd;
    logic [DW+1:0]          sh;
    logic signed [DW+2:0]   y_wide;
    logic [DW-1:0]          y_n;

    // Sign-extended operands at full product width keep the multiply exact.
    always_comb begin
        diff_x = {{FB{s1_diff[DW]}}, s1_diff};
        frac_x = {{(DW + 1){1'b0}}, s1_frac};
        prod_n = diff_x * frac_x;
        rnd    = {s2_prod[PW-1], s2_prod} + HALF;
        sh     = rnd[PW:FB];
        y_wide = {sh[DW+1], sh} + {3'b000, s2_lo};
        y_n    = DW'(clamp_u(64'(y_wide), DW));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_lo   <= '0;
            s1_diff <= '0;
            s1_frac <= '0;
            s1_x    <= '0;
            s2_lo   <= '0;
            s2_prod <= '0;
            s2_x    <= '0;
            y       <= '0;
        end else begin
            if (in_valid) begin
                s1_lo   <= k_lo;
                s1_diff <= diff_n;
                s1_frac <= x[FB-1:0];
                s1_x    <= x;
            end
            if (v1) begin
                s2_lo   <= s1_lo;
                s2_prod <= prod_n;
                s2_x    <= s1_x;
            end
            if (v2)
                y <= byp2 ? s2_x : y_n;
        end
    end

endmodule

// File: rtl/gamma_corrector_pwl.sv
// Multi-channel PWL gamma corrector: shared valid/bypass pipeline, LUT write decode and bank-swap control.
module gamma_corrector_pwl
    import gamma_pkg::*;
#(
    parameter  int DW       = DW_DEF,
    parameter  int NCH      = NCH_DEF,
    parameter  int SEG_BITS = SEG_BITS_DEF,
    localparam int CHW      = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inpvalid,
    input  logic [NCH*DW-1:0]   din,
    input  logic                bypass,
    input  logic                lut_we,
    input  logic [CHW-1:0]      lut_ch,
    input  logic [SEG_BITS:0]   lut_addr,
    input  logic [DW-1:0]       lut_wdata,
    input  logic                lut_commit,
    output logic                outvalid,
    output logic [NCH*DW-1:0]   dout,
    output logic                commit_pending
);

    localparam logic [SEG_BITS:0] NK_W = (SEG_BITS + 1)'(nknot(SEG_BITS));

    logic v1, v2, v3;
    logic b1, b2;
    logic sel;
    logic swap;
    logic pending_n;
    logic addr_ok;

    // A swap only happens with nothing entering and nothing in flight.
    always_comb begin
        swap      = commit_pending && !inpvalid && !v1 && !v2 && !v3;
        pending_n = swap ? 1'b0 : (commit_pending || lut_commit);
        addr_ok   = lut_addr < NK_W;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1             <= 1'b0;
            v2             <= 1'b0;
            v3             <= 1'b0;
            b1             <= 1'b0;
            b2             <= 1'b0;
            sel            <= 1'b0;
            commit_pending <= 1'b0;
        end else begin
            v1             <= inpvalid;
            v2             <= v1;
            v3             <= v2;
            b1             <= bypass;
            b2             <= b1;
            sel            <= sel ^ swap;
            commit_pending <= pending_n;
        end
    end

    assign outvalid = v3;

    for (genvar k = 0; k < NCH; k++) begin : g_lane
        logic we_k;
        assign we_k = lut_we && addr_ok && (lut_ch == CHW'(k));

        gamma_pwl_lane #(
            .DW       (DW),
            .SEG_BITS (SEG_BITS)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .in_valid (inpvalid),
            .v1       (v1),
            .v2       (v2),
            .byp2     (b2),
            .sel      (sel),
            .we       (we_k),
            .waddr    (lut_addr),
            .wdata    (lut_wdata),
            .x        (din[k*DW +: DW]),
            .y        (dout[k*DW +: DW])
        );
    end

endmodule

// File: doc/gamma_corrector_pwl.md
GAMMA_CORRECTOR_PWL -- requirements
Module: gamma_corrector_pwl

Interface
REQ-001 Parameter DW, default 12: bits per colour plane.
REQ-002 Parameter NCH, default 3: colour planes processed in parallel.
REQ-003 Parameter SEG_BITS, default 5: log2 of segment count. FRAC_BITS = DW-SEG_BITS. NKNOT = 2^SEG_BITS+1 knots per channel.
REQ-004 clk  in  1  system clock; single clock domain.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 inpvalid  in  1  din qualifier.
REQ-007 din  in  NCH*DW  packed planes; plane k at bits [k*DW +: DW].
REQ-008 bypass  in  1  sampled with each beat; 1 passes that beat uncorrected.
REQ-009 lut_we  in  1  knot write strobe.
REQ-010 lut_ch  in  clog2(NCH) (min 1)  target channel.
REQ-011 lut_addr  in  SEG_BITS+1  knot index.
REQ-012 lut_wdata  in  DW  knot value.
REQ-013 lut_commit  in  1  pulse; requests a shadow/active bank swap.
REQ-014 outvalid  out  1  dout qualifier.
REQ-015 dout  out  NCH*DW  corrected planes, same packing as din.
REQ-016 commit_pending  out  1  swap requested but not yet applied.

Function
REQ-017 Per channel, two knot banks: active (read by the datapath) and shadow (written by lut_we); no backpressure; one beat accepted per cycle.
REQ-018 Fixed latency 3: outvalid at cycle N+3 equals inpvalid at cycle N; dout holds its value while outvalid=0.
REQ-019 Stage 1: seg = x[DW-1:FRAC_BITS], frac = x[FRAC_BITS-1:0]; register lo = K[seg] and signed diff = K[seg+1]-K[seg] (DW+1 bits).
REQ-020 Stage 2: register prod = diff*frac (signed, DW+FRAC_BITS+1 bits).
REQ-021 Stage 3: y = lo + ((prod + 2^(FRAC_BITS-1)) >>> FRAC_BITS); clamp to [0, 2^DW-1]; register.
REQ-022 Bypass beat: dout = din of that beat, same 3-cycle latency; the bypass flag travels down the pipeline with the beat.
REQ-023 lut_we=1 writes lut_wdata to shadow[lut_ch][lut_addr]; writes with lut_addr >= NKNOT or lut_ch >= NCH are ignored.
REQ-024 lut_commit sets commit_pending. The swap occurs on the first cycle in which commit_pending=1, inpvalid=0, and all three pipeline stages are empty. That cycle clears commit_pending and exchanges the active and shadow bank roles. No data is copied between banks.
REQ-025 lut_commit while commit_pending=1: no additional effect.
REQ-026 lut_we and the swap in the same cycle: the write lands in the pre-swap shadow bank, i.e. it becomes active.
REQ-027 Beats already in flight always complete using the bank that was active when they entered.

Reset
REQ-028 rst=1: outvalid=0, dout=0, commit_pending=0, all pipeline valid bits=0, bank select=0.
REQ-029 rst=1 loads identity into both banks: K[i] = min(i*2^FRAC_BITS, 2^DW-1).
REQ-030 rst asserted mid-operation discards in-flight beats and any pending commit; outvalid=0 on the cycle after rst.

Structure
REQ-031 Shared package gamma_pkg holds DW/NCH/SEG_BITS defaults, FRAC_BITS, an NKNOT function, and the clamp helper.
REQ-032 Sub-module gamma_pwl_lane: one channel's banks plus its 3-stage datapath. The top instantiates NCH lanes, holds the shared valid, bypass and commit control, and decodes lut_ch.

Verification
REQ-033 After reset, inpvalid=1, din plane0=0x800, bypass=0 -> 3 cycles later outvalid=1, dout plane0=0x800.
REQ-034 Shadow ch0 K[16]=0x100, K[17]=0x300, then commit with the pipeline idle, then input 0x840 (seg 16, frac 64) -> dout plane0=0x200; commit_pending cleared 1 cycle after the pulse.
REQ-035 Commit pulse issued during a 10-beat continuous valid burst -> commit_pending stays 1 through the burst plus 3 drain cycles; all 10 beats use the old table; the swap occurs on the first fully idle cycle.
REQ-036 Shadow K[0]=0xFFF, K[1]=0x000, committed, then input 0x07F -> result lies in range, no wrap; an underflowing table (K[0]=0, K[1] written through diff such that y<0 is impossible only via rounding) is covered by a clamp check at 0.
REQ-037 bypass=1 with din=0xABC on all planes and a non-identity table -> dout=0xABC on all planes at latency 3.
REQ-038 rst asserted for 1 cycle with 2 beats in flight and commit pending -> neither beat appears on outvalid, commit_pending=0, tables revert to identity.
